dmem_responder: RTL

Data-memory responder (slave) for the core's dmem request interface: accepts load/store requests (dmem_req, dmem_wr_en, dmem_size, dmem_zero_extend, dmem_addr, dmem_wr_data) and returns data after a programmable wait-state latency.
- Handles byte/half/word lane placement, sign/zero extension, and alignment/range errors.
- Replaces the zero-latency data memory when the pipelined/multi-cycle core needs a stalling memory.

---
 rtl/risc_pkg.sv | 20 ++
 rtl/dmem_lane_align.sv | 56 +++++
 rtl/dmem_responder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared types for the core's memory interfaces.
package risc_pkg;

    // Access size shared by control and data memory paths.
    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } mem_size_t;

    // Data-memory responder FSM states.
    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_t;

    localparam int unsigned DMEM_CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/half/word lane handling for loads (extract + extend) and stores (merge).
module dmem_lane_align
    import risc_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [1:0]  addr_lo,
    input  mem_size_t   size,
    input  logic        zero_extend,
    input  logic [31:0] wr_data,
    output logic [31:0] load_data_c,
    output logic [31:0] store_word_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Load path: select the addressed lane and extend it to 32 bits.
    always_comb begin
        byte_sel    = mem_word[7:0];
        half_sel    = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
        load_data_c = mem_word;
        case (addr_lo)
            2'd0:    byte_sel = mem_word[7:0];
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            default: byte_sel = mem_word[31:24];
        endcase
        case (size)
            BYTE:      load_data_c = {{24{~zero_extend & byte_sel[7]}}, byte_sel};
            HALF_WORD: load_data_c = {{16{~zero_extend & half_sel[15]}}, half_sel};
            default:   load_data_c = mem_word;
        endcase
    end

    // Store path: merge the LSB-justified store data into the old word.
    always_comb begin
        store_word_c = mem_word;
        case (size)
            BYTE: begin
                case (addr_lo)
                    2'd0:    store_word_c[7:0]   = wr_data[7:0];
                    2'd1:    store_word_c[15:8]  = wr_data[7:0];
                    2'd2:    store_word_c[23:16] = wr_data[7:0];
                    default: store_word_c[31:24] = wr_data[7:0];
                endcase
            end
            HALF_WORD: begin
                if (addr_lo[1]) store_word_c[31:16] = wr_data[15:0];
                else            store_word_c[15:0]  = wr_data[15:0];
            end
            WORD:    store_word_c = wr_data;
            default: store_word_c = mem_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait-state latency.
module dmem_responder
    import risc_pkg::*;
#(
    parameter int unsigned MEM_DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY         = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_req,
    input  logic        dmem_wr_en,
    input  mem_size_t   dmem_size,
    input  logic        dmem_zero_extend,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wr_data,
    output logic        dmem_ready,
    output logic        dmem_ack,
    output logic        dmem_err,
    output logic [31:0] dmem_rd_data
);

    localparam int unsigned IDX_W      = $clog2(MEM_DEPTH_WORDS);
    localparam int unsigned BYTE_LIMIT = MEM_DEPTH_WORDS * 4;
    localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
        (LATENCY >= 2) ? DMEM_CNT_W'(LATENCY - 2) : '0;

    dmem_state_t            state_q, state_d;
    logic [DMEM_CNT_W-1:0]  cnt_q, cnt_d;
    logic                   accept;
    logic                   enter_resp;

    logic                   cap_wr_en, cap_zext;
    mem_size_t              cap_size;
    logic [31:0]            cap_addr, cap_wr_data;

    logic                   eff_wr_en, eff_zext;
    mem_size_t              eff_size;
    logic [31:0]            eff_addr, eff_wr_data;
    logic                   access_err;
    logic [IDX_W-1:0]       mem_idx;
    logic [31:0]            mem_word;
    logic [31:0]            load_data_c;
    logic [31:0]            store_word_c;

    logic [31:0]            mem [MEM_DEPTH_WORDS];

    assign accept = dmem_req & dmem_ready;

    // Live inputs in IDLE (LATENCY=1 enters RESP on the accept edge), captured copy otherwise.
    always_comb begin
        eff_wr_en   = cap_wr_en;
        eff_zext    = cap_zext;
        eff_size    = cap_size;
        eff_addr    = cap_addr;
        eff_wr_data = cap_wr_data;
        if (state_q == DMEM_IDLE) begin
            eff_wr_en   = dmem_wr_en;
            eff_zext    = dmem_zero_extend;
            eff_size    = dmem_size;
            eff_addr    = dmem_addr;
            eff_wr_data = dmem_wr_data;
        end
    end

    // Alignment, reserved-size and range fault detection.
    always_comb begin
        access_err = 1'b0;
        case (eff_size)
            BYTE:      access_err = 1'b0;
            HALF_WORD: access_err = eff_addr[0];
            WORD:      access_err = |eff_addr[1:0];
            default:   access_err = 1'b1;
        endcase
        if (eff_addr >= 32'(BYTE_LIMIT)) access_err = 1'b1;
    end

    assign mem_idx  = eff_addr[IDX_W+1:2];
    assign mem_word = mem[mem_idx];

    dmem_lane_align u_lane_align (
        .mem_word     (mem_word),
        .addr_lo      (eff_addr[1:0]),
        .size         (eff_size),
        .zero_extend  (eff_zext),
        .wr_data      (eff_wr_data),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c)
    );

    // Next-state and wait-counter logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                if (accept) begin
                    if (LATENCY <= 1) begin
                        state_d = DMEM_RESP;
                    end else begin
                        state_d = DMEM_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            DMEM_WAIT: begin
                if (cnt_q == '0) state_d = DMEM_RESP;
                else             cnt_d   = cnt_q - DMEM_CNT_W'(1);
            end
            DMEM_RESP: state_d = DMEM_IDLE;
            default:   state_d = DMEM_IDLE;
        endcase
        enter_resp = (state_d == DMEM_RESP) && (state_q != DMEM_RESP);
    end

    // State, counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= DMEM_IDLE;
            cnt_q        <= '0;
            dmem_ready   <= 1'b1;
            dmem_ack     <= 1'b0;
            dmem_err     <= 1'b0;
            dmem_rd_data <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dmem_ready <= (state_d == DMEM_IDLE);
            dmem_ack   <= (state_d == DMEM_RESP);
            dmem_err   <= enter_resp & access_err;
            if (enter_resp) begin
                if (access_err)      dmem_rd_data <= '0;
                else if (!eff_wr_en) dmem_rd_data <= load_data_c;
            end
        end
    end

    // Request capture on accept so the requester may move on.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_wr_en   <= dmem_wr_en;
            cap_zext    <= dmem_zero_extend;
            cap_size    <= dmem_size;
            cap_addr    <= dmem_addr;
            cap_wr_data <= dmem_wr_data;
        end
    end

    // Store commit on the edge entering RESP; a reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && eff_wr_en && !access_err) begin
            mem[mem_idx] <= store_word_c;
        end
    end

endmodule
